// File: rtl/regfile_write_bank_pkg.sv
// Shared constants for the integer register file write side.
package regfile_write_bank_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int NREG   = 2 ** ADDR_W;

  // Architectural zero register (XZR).
  localparam logic [ADDR_W-1:0] XZR_IDX = 5'd31;

  // Value every register takes on reset.
  localparam logic [DATA_W-1:0] RST_VAL = 64'd0;

endpackage

// File: rtl/regfile_write_bank_decoder5to32.sv
// One-hot write-enable decoder; structural mirror of the 32:1 read mux.
module decoder5to32 #(
  parameter int ADDR_W = regfile_write_bank_pkg::ADDR_W,
  parameter int NREG   = regfile_write_bank_pkg::NREG
) (
  input  logic              en,
  input  logic [ADDR_W-1:0] sel,
  output logic [NREG-1:0]   onehot
);

  // Raise exactly the selected line when enabled, none otherwise.
  // NOTE: the default assignment first means every path writes onehot, so no latch is inferred.
  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_write_bank.sv
// Write side of the integer register file: one staging slot, one-hot commit,
// flat export of all registers and of the pending write for forwarding.
module regfile_write_bank #(
  parameter int DATA_W   = regfile_write_bank_pkg::DATA_W,
  parameter int ADDR_W   = regfile_write_bank_pkg::ADDR_W,
  parameter int NREG     = regfile_write_bank_pkg::NREG,
  parameter bit ZERO_EN  = 1'b1,
  parameter int ZERO_IDX = int'(regfile_write_bank_pkg::XZR_IDX)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   pend_vld,
  output logic [ADDR_W-1:0]      pend_addr,
  output logic [DATA_W-1:0]      pend_data,
  output logic                   wr_ack,
  output logic [NREG*DATA_W-1:0] q_flat
);

  import regfile_write_bank_pkg::RST_VAL;

  // Registers that never accept a commit (the zero register when enabled).
  localparam logic [NREG-1:0] ZERO_MASK = ZERO_EN ? (NREG'(1) << ZERO_IDX) : '0;

  logic [NREG-1:0]   dec_onehot;
  logic [NREG-1:0]   commit_en;
  logic [DATA_W-1:0] regs [NREG];

  // Staging slot: capture a request each edge; an idle cycle empties the slot.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld  <= 1'b0;
      pend_addr <= '0;
      pend_data <= DATA_W'(RST_VAL);
    end else begin
      pend_vld <= wr_en;
      if (wr_en) begin
        pend_addr <= wr_addr;
        pend_data <= wr_data;
      end
    end
  end

  // Acknowledge: the slot content commits on this edge, so pulse for the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ack <= 1'b0;
    end else begin
      wr_ack <= pend_vld;
    end
  end

  decoder5to32 #(
    .ADDR_W (ADDR_W),
    .NREG   (NREG)
  ) u_dec (
    .en     (pend_vld),
    .sel    (pend_addr),
    .onehot (dec_onehot)
  );

  // Zero register drops its enable; the staged request and ack are unaffected.
  assign commit_en = dec_onehot & ~ZERO_MASK;

  // Register array: the single enabled register takes the staged data.
  // NOTE: this array is flop-based architectural state that must read zero after reset, so it is reset (unlike a RAM macro).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= DATA_W'(RST_VAL);
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (commit_en[i]) begin
          regs[i] <= pend_data;
        end
      end
    end
  end

  // Flat export to the read multiplexers.
  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign q_flat[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule

// File: tb/tb_regfile_write_bank.sv
// Self-checking bench: directed plan plus random traffic, scoreboard of staged
// requests checked by an independent monitor against an architectural model.
module tb_regfile_write_bank;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [4:0]    wr_addr;
  logic [63:0]   wr_data;

  logic          pend_vld_z,  pend_vld_n;
  logic [4:0]    pend_addr_z, pend_addr_n;
  logic [63:0]   pend_data_z, pend_data_n;
  logic          wr_ack_z,    wr_ack_n;
  logic [2047:0] q_flat_z,    q_flat_n;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          en;
    logic [4:0]  addr;
    logic [63:0] data;
  } req_t;

  // One entry per active clock edge: the request presented to that edge.
  req_t stage_q[$];

  // Architectural register contents expected after each edge.
  logic [63:0] exp_z [32];
  logic [63:0] exp_n [32];

  regfile_write_bank #(.ZERO_EN(1'b1)) u_dut_z (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .pend_vld  (pend_vld_z),
    .pend_addr (pend_addr_z),
    .pend_data (pend_data_z),
    .wr_ack    (wr_ack_z),
    .q_flat    (q_flat_z)
  );

  regfile_write_bank #(.ZERO_EN(1'b0)) u_dut_n (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .pend_vld  (pend_vld_n),
    .pend_addr (pend_addr_n),
    .pend_data (pend_data_n),
    .wr_ack    (wr_ack_n),
    .q_flat    (q_flat_n)
  );

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] reg_of(input logic [2047:0] q, input int i);
    return q[i*64 +: 64];
  endfunction

  // Compare all 32 registers; report the first one that differs.
  task automatic cmp_regs(input string tag, input logic [2047:0] q, input logic [63:0] exp [32]);
    int bad = -1;
    for (int i = 0; i < 32; i++) begin
      if (bad < 0 && reg_of(q, i) !== exp[i]) bad = i;
    end
    if (bad < 0) check(1'b1, tag, 64'd0, 64'd0);
    else check(1'b0, $sformatf("%s_reg%0d", tag, bad), reg_of(q, bad), exp[bad]);
  endtask

  // Monitor: samples 2 time units after every rising edge.
  initial begin : monitor
    req_t cur;
    req_t prev;
    bit   have_prev = 1'b0;
    bit   exp_ack;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        have_prev = 1'b0;
        for (int i = 0; i < 32; i++) begin
          exp_z[i] = 64'd0;
          exp_n[i] = 64'd0;
        end
        check(pend_vld_z == 1'b0, "rst_pend_vld", 64'(pend_vld_z), 64'd0);
        check(pend_addr_z == 5'd0, "rst_pend_addr", 64'(pend_addr_z), 64'd0);
        check(pend_data_z == 64'd0, "rst_pend_data", pend_data_z, 64'd0);
        check(wr_ack_z == 1'b0 && wr_ack_n == 1'b0, "rst_wr_ack", 64'(wr_ack_z), 64'd0);
        cmp_regs("rst_q_z", q_flat_z, exp_z);
        cmp_regs("rst_q_n", q_flat_n, exp_n);
      end else if (stage_q.size() == 0) begin
        check(1'b0, "scoreboard_underflow", 64'd0, 64'd1);
      end else begin
        cur = stage_q.pop_front();
        // A request staged on the previous edge lands on this edge.
        exp_ack = have_prev && prev.en;
        if (exp_ack) begin
          exp_n[prev.addr] = prev.data;
          if (prev.addr != 5'd31) exp_z[prev.addr] = prev.data;
        end
        check(wr_ack_z == exp_ack, "wr_ack_z", 64'(wr_ack_z), 64'(exp_ack));
        check(wr_ack_n == exp_ack, "wr_ack_n", 64'(wr_ack_n), 64'(exp_ack));
        check(pend_vld_z == cur.en, "pend_vld_z", 64'(pend_vld_z), 64'(cur.en));
        check(pend_vld_n == cur.en, "pend_vld_n", 64'(pend_vld_n), 64'(cur.en));
        if (cur.en) begin
          check(pend_addr_z == cur.addr, "pend_addr_z", 64'(pend_addr_z), 64'(cur.addr));
          check(pend_data_z == cur.data, "pend_data_z", pend_data_z, cur.data);
          check(pend_addr_n == cur.addr && pend_data_n == cur.data, "pend_n", pend_data_n, cur.data);
        end
        cmp_regs("q_z", q_flat_z, exp_z);
        cmp_regs("q_n", q_flat_n, exp_n);
        prev      = cur;
        have_prev = 1'b1;
      end
    end
  end

  // Present one request (or idle) to the next rising edge.
  task automatic cyc(input bit en, input logic [4:0] a, input logic [63:0] d);
    req_t r;
    @(negedge clk);
    wr_en   = en;
    wr_addr = a;
    wr_data = d;
    r.en    = en;
    r.addr  = a;
    r.data  = d;
    stage_q.push_back(r);
  endtask

  task automatic release_rst();
    req_t r;
    @(negedge clk);
    rst     = 1'b0;
    wr_en   = 1'b0;
    r.en    = 1'b0;
    r.addr  = 5'd0;
    r.data  = 64'd0;
    stage_q.push_back(r);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : driver
    logic [4:0]  a;
    logic [4:0]  last_a = 5'd0;
    logic [63:0] ones = '1;
    rst     = 1'b1;
    wr_en   = 1'b1;   // ignored while in reset
    wr_addr = 5'd3;
    wr_data = 64'h1234;
    repeat (3) @(negedge clk);
    release_rst();

    // Single write.
    cyc(1'b1, 5'd5, 64'hDEAD_BEEF_0123_4567);
    cyc(1'b0, 5'd0, 64'd0);
    check(pend_vld_z == 1'b1 && pend_addr_z == 5'd5, "single_pend", 64'(pend_addr_z), 64'd5);
    cyc(1'b0, 5'd0, 64'd0);
    check(reg_of(q_flat_z, 5) == 64'hDEAD_BEEF_0123_4567, "single_reg5", reg_of(q_flat_z, 5), 64'hDEAD_BEEF_0123_4567);

    // Back-to-back distinct writes.
    cyc(1'b1, 5'd0, 64'd1);
    cyc(1'b1, 5'd1, 64'd2);
    cyc(1'b1, 5'd2, 64'd3);
    cyc(1'b1, 5'd30, 64'd4);
    cyc(1'b0, 5'd0, 64'd0);
    cyc(1'b0, 5'd0, 64'd0);
    check(reg_of(q_flat_z, 0) == 64'd1 && reg_of(q_flat_z, 1) == 64'd2, "b2b_reg01", reg_of(q_flat_z, 1), 64'd2);
    check(reg_of(q_flat_z, 2) == 64'd3 && reg_of(q_flat_z, 30) == 64'd4, "b2b_reg230", reg_of(q_flat_z, 30), 64'd4);

    // Same-address hazard.
    cyc(1'b1, 5'd7, 64'hAA);
    cyc(1'b1, 5'd7, 64'hBB);
    cyc(1'b0, 5'd0, 64'd0);
    check(pend_data_z == 64'hBB, "hazard_pend_data", pend_data_z, 64'hBB);
    check(reg_of(q_flat_z, 7) == 64'hAA, "hazard_reg7_first", reg_of(q_flat_z, 7), 64'hAA);
    cyc(1'b0, 5'd0, 64'd0);
    check(reg_of(q_flat_z, 7) == 64'hBB, "hazard_reg7_final", reg_of(q_flat_z, 7), 64'hBB);

    // Zero register, both builds.
    cyc(1'b1, 5'd31, ones);
    cyc(1'b0, 5'd0, 64'd0);
    cyc(1'b0, 5'd0, 64'd0);
    check(reg_of(q_flat_z, 31) == 64'd0, "xzr_z_reg31", reg_of(q_flat_z, 31), 64'd0);
    check(reg_of(q_flat_n, 31) == ones, "xzr_n_reg31", reg_of(q_flat_n, 31), ones);

    // Reset mid-operation: staged write is discarded.
    cyc(1'b1, 5'd9, 64'h55);
    @(posedge clk);
    #3;
    rst     = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 5'd9;
    wr_data = 64'h77;
    stage_q.delete();
    #1;
    check(pend_vld_z == 1'b0, "midrst_pend_vld", 64'(pend_vld_z), 64'd0);
    check(wr_ack_z == 1'b0, "midrst_wr_ack", 64'(wr_ack_z), 64'd0);
    check(q_flat_z == '0, "midrst_qflat_zero", 64'(|q_flat_z), 64'd0);
    @(negedge clk);
    release_rst();
    cyc(1'b0, 5'd0, 64'd0);
    check(reg_of(q_flat_z, 9) == 64'd0 && wr_ack_z == 1'b0, "midrst_no_commit", reg_of(q_flat_z, 9), 64'd0);
    cyc(1'b1, 5'd9, 64'h66);
    cyc(1'b0, 5'd0, 64'd0);
    cyc(1'b0, 5'd0, 64'd0);
    check(reg_of(q_flat_z, 9) == 64'h66, "postrst_reg9", reg_of(q_flat_z, 9), 64'h66);

    // Random traffic with a bias toward the zero register and repeated addresses.
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(5))
        0:       a = 5'd31;
        1:       a = last_a;
        default: a = 5'($urandom_range(31));
      endcase
      last_a = a;
      cyc($urandom_range(3) != 0, a, {$urandom, $urandom});
    end
    cyc(1'b0, 5'd0, 64'd0);
    cyc(1'b0, 5'd0, 64'd0);

    @(posedge clk);
    #4;
    check(stage_q.size() == 0, "scoreboard_drained", 64'(stage_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_bank.md
Name: regfile_write_bank

Overview:
- Write side of the 32 x 64-bit integer register file.
- A write request is registered into one staging slot, decoded 5-to-32, and committed to the addressed register on the next clock edge.
- All 32 register values are exported flat to the existing 32:1 read multiplexers.
- The pending (staged) write is exported so read-side forwarding can bypass it.

Parameters:
- DATA_W, 64, register width in bits
- ADDR_W, 5, register index width
- NREG, 32, number of registers (2**ADDR_W)
- ZERO_EN, 1, when 1 register ZERO_IDX is hardwired to 0
- ZERO_IDX, 31, index of the zero register (XZR)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- wr_en  input  1  write request this cycle
- wr_addr  input  ADDR_W  destination register index
- wr_data  input  DATA_W  write data
- pend_vld  output  1  staging slot holds an uncommitted write
- pend_addr  output  ADDR_W  staged destination index
- pend_data  output  DATA_W  staged write data
- wr_ack  output  1  one-cycle pulse: staged write committed on this edge
- q_flat  output  NREG*DATA_W  register i at bits [i*DATA_W +: DATA_W]

Behaviour:
- Reset is asynchronous and active-high. While rst=1:
  - all registers = 0
  - pend_vld = 0, pend_addr = 0, pend_data = 0
  - wr_ack = 0
  - q_flat = 0
- Stage (edge N): if wr_en=1, capture wr_addr/wr_data into the slot and set pend_vld=1. If wr_en=0, clear pend_vld.
- Commit (edge N+1): if pend_vld=1, the register at pend_addr takes pend_data. wr_ack is 1 during the cycle after that edge.
- Latency:
  - A request at edge N is visible on q_flat after edge N+1.
  - wr_ack is high for the cycle following edge N+1.
- Throughput: one write per cycle, no stall. Back-to-back requests overlap: commit of slot contents and capture of the new request happen on the same edge.
- Same-address back-to-back writes: later data wins and both are acked. Final register = second value.
- Zero register (ZERO_EN=1, pend_addr=ZERO_IDX):
  - The commit is suppressed; the register stays 0.
  - wr_ack still pulses.
  - pend_vld/pend_addr/pend_data still expose the staged request; forwarding logic must itself mask ZERO_IDX.
- ZERO_EN=0: ZERO_IDX is an ordinary register.
- Decode: exactly one register enable is active when pend_vld=1, and none when pend_vld=0. Out-of-range indices are not possible because NREG = 2**ADDR_W.
- Reset mid-operation: a staged write is discarded and never committed; wr_ack is not emitted for it. The first request after deassertion behaves normally.
- wr_en=1 during reset is ignored.
- No read ports here; read muxing stays in the existing mux blocks fed from q_flat.

Decomposition:
- Shared package holds:
  - DATA_W, ADDR_W, NREG
  - XZR_IDX = 5'd31
  - the reset value constant (64'd0)
- One sub-module, decoder5to32: combinational one-hot decoder with enable input (pend_vld) and 5-bit select. It is the structural counterpart of the 32:1 read mux.
- Staging slot, register array, and zero masking stay in the top module.

Test Plan:
- Reset then single write: wr_en=1, addr=5, data=64'hDEAD_BEEF_0123_4567 at edge 1 ->
  - pend_vld=1, pend_addr=5 after edge 1
  - reg5 = DEADBEEF01234567 and wr_ack=1 after edge 2
  - all other registers = 0
- Back-to-back distinct writes over edges 1..4: addrs 0, 1, 2, 30 with data 1, 2, 3, 4 ->
  - wr_ack high for 4 consecutive cycles starting after edge 2
  - reg0=1, reg1=2, reg2=3, reg30=4
- Same-address hazard: writes to addr 7 with data 0xAA then 0xBB on consecutive edges ->
  - pend_data=0xBB while reg7=0xAA (for one cycle)
  - reg7=0xBB afterwards
- Zero register, ZERO_EN=1: write addr 31, data 64'hFFFF_FFFF_FFFF_FFFF ->
  - wr_ack pulses
  - reg31 reads 0
  - no other register changes
- ZERO_EN=0 build: same stimulus -> reg31 = all ones.
- Reset mid-operation: write addr 9 data 0x55 staged at edge 1, rst asserted asynchronously before edge 2 ->
  - pend_vld=0 immediately
  - reg9=0 and no wr_ack after deassertion
  - a subsequent write to addr 9 with data 0x66 commits normally
